// File: rtl/serdes_qpll_reset_ctl.sv
// Power-down, reset and lock supervision sequencer for GTXE2_COMMON quad PLLs.
// Each channel runs an independent PWRDN -> RESET -> WAIT_LOCK -> SETTLE -> READY sequence.
module serdes_qpll_reset_ctl #(
  parameter int NUM_QPLLS     = 2,
  parameter int PD_CYCLES     = 64,
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 125000,
  parameter int SETTLE_CYCLES = 1250,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                           clk_125mhz,
  input  logic                           rst,
  input  logic [NUM_QPLLS-1:0]           qpll_lock,
  input  logic [NUM_QPLLS-1:0]           qpll_refclk_lost,
  input  logic [NUM_QPLLS-1:0]           qpll_restart,
  output logic [NUM_QPLLS-1:0]           qpll_pd,
  output logic [NUM_QPLLS-1:0]           qpll_reset,
  output logic [NUM_QPLLS-1:0]           qpll_ready,
  output logic                           all_ready,
  output logic [NUM_QPLLS*CNT_WIDTH-1:0] fault_count
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max_of(max_of(PD_CYCLES, RESET_CYCLES), max_of(LOCK_TIMEOUT, SETTLE_CYCLES));
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0]        PD_LAST     = TW'(PD_CYCLES - 1);
  localparam logic [TW-1:0]        RESET_LAST  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0]        LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]        SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]        TIMER_ZERO  = TW'(0);
  localparam logic [TW-1:0]        TIMER_ONE   = TW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    PWRDN     = 3'd0,
    RESET     = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    READY     = 3'd4
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [NUM_QPLLS-1:0] lock_meta;
  logic [NUM_QPLLS-1:0] lock_s;
  logic [NUM_QPLLS-1:0] lost_meta;
  logic [NUM_QPLLS-1:0] lost_s;

  // Two-flop synchronisers for the asynchronous QPLL status pins.
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      lock_meta <= {NUM_QPLLS{1'b0}};
      lock_s    <= {NUM_QPLLS{1'b0}};
      lost_meta <= {NUM_QPLLS{1'b0}};
      lost_s    <= {NUM_QPLLS{1'b0}};
    end else begin
      lock_meta <= qpll_lock;
      lock_s    <= lock_meta;
      lost_meta <= qpll_refclk_lost;
      lost_s    <= lost_meta;
    end
  end

  // Registered summary of all channels.
  always_ff @(posedge clk_125mhz) begin
    if (rst) begin
      all_ready <= 1'b0;
    end else begin
      all_ready <= &qpll_ready;
    end
  end

  for (genvar i = 0; i < NUM_QPLLS; i++) begin : g_ch
    state_t               state;
    logic [TW-1:0]        timer;
    logic                 pd_drive;
    logic                 reset_drive;
    logic                 ready_flag;
    logic [CNT_WIDTH-1:0] faults;

    // Per-channel sequencer; outputs are set alongside the state they belong to.
    always_ff @(posedge clk_125mhz) begin
      if (rst) begin
        state       <= PWRDN;
        timer       <= TIMER_ZERO;
        pd_drive    <= 1'b1;
        reset_drive <= 1'b1;
        ready_flag  <= 1'b0;
        faults      <= {CNT_WIDTH{1'b0}};
      end else if (state == PWRDN) begin
        if (timer == PD_LAST) begin
          state    <= RESET;
          timer    <= TIMER_ZERO;
          pd_drive <= 1'b0;
        end else begin
          timer <= timer + TIMER_ONE;
        end
      end else if (lost_s[i] || qpll_restart[i]) begin
        // Holding RESET with the timer at zero keeps the pulse asserted until refclk returns.
        state       <= RESET;
        timer       <= TIMER_ZERO;
        pd_drive    <= 1'b0;
        reset_drive <= 1'b1;
        ready_flag  <= 1'b0;
        if (lost_s[i] && (state == READY)) begin
          faults <= sat_inc(faults);
        end
      end else begin
        case (state)
          RESET: begin
            if (timer == RESET_LAST) begin
              state       <= WAIT_LOCK;
              timer       <= TIMER_ZERO;
              reset_drive <= 1'b0;
            end else begin
              timer <= timer + TIMER_ONE;
            end
          end
          WAIT_LOCK: begin
            if (lock_s[i]) begin
              state <= SETTLE;
              timer <= TIMER_ZERO;
            end else if (timer == LOCK_LAST) begin
              state       <= RESET;
              timer       <= TIMER_ZERO;
              reset_drive <= 1'b1;
              faults      <= sat_inc(faults);
            end else begin
              timer <= timer + TIMER_ONE;
            end
          end
          SETTLE: begin
            if (!lock_s[i]) begin
              state       <= RESET;
              timer       <= TIMER_ZERO;
              reset_drive <= 1'b1;
              faults      <= sat_inc(faults);
            end else if (timer == SETTLE_LAST) begin
              state      <= READY;
              timer      <= TIMER_ZERO;
              ready_flag <= 1'b1;
            end else begin
              timer <= timer + TIMER_ONE;
            end
          end
          READY: begin
            if (!lock_s[i]) begin
              state       <= RESET;
              timer       <= TIMER_ZERO;
              reset_drive <= 1'b1;
              ready_flag  <= 1'b0;
              faults      <= sat_inc(faults);
            end else begin
              timer <= TIMER_ZERO;
            end
          end
          default: begin
            state       <= PWRDN;
            timer       <= TIMER_ZERO;
            pd_drive    <= 1'b1;
            reset_drive <= 1'b1;
            ready_flag  <= 1'b0;
          end
        endcase
      end
    end

    assign qpll_pd[i]                               = pd_drive;
    assign qpll_reset[i]                            = reset_drive;
    assign qpll_ready[i]                            = ready_flag;
    assign fault_count[i*CNT_WIDTH +: CNT_WIDTH]    = faults;
  end

endmodule

// File: tb/tb_serdes_qpll_reset_ctl.sv
// Directed bench for serdes_qpll_reset_ctl with small timing parameters.
module tb_serdes_qpll_reset_ctl;

  logic        clk;
  logic        rst;
  logic [1:0]  qpll_lock;
  logic [1:0]  qpll_refclk_lost;
  logic [1:0]  qpll_restart;
  logic [1:0]  qpll_pd;
  logic [1:0]  qpll_reset;
  logic [1:0]  qpll_ready;
  logic        all_ready;
  logic [15:0] fault_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  serdes_qpll_reset_ctl #(
    .NUM_QPLLS(2), .PD_CYCLES(4), .RESET_CYCLES(3),
    .LOCK_TIMEOUT(20), .SETTLE_CYCLES(5), .CNT_WIDTH(8)
  ) dut (
    .clk_125mhz(clk),
    .rst(rst),
    .qpll_lock(qpll_lock),
    .qpll_refclk_lost(qpll_refclk_lost),
    .qpll_restart(qpll_restart),
    .qpll_pd(qpll_pd),
    .qpll_reset(qpll_reset),
    .qpll_ready(qpll_ready),
    .all_ready(all_ready),
    .fault_count(fault_count)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Leaves the bench at cycle 0: the first cycle after rst falls.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    qpll_lock = 2'b00;
    qpll_refclk_lost = 2'b00;
    qpll_restart = 2'b00;
    repeat (3) tick();
    checks++; if (qpll_pd !== 2'b11) begin errors++; $display("FAIL reset_pd got=%b exp=11", qpll_pd); end
    checks++; if (qpll_reset !== 2'b11) begin errors++; $display("FAIL reset_reset got=%b exp=11", qpll_reset); end
    checks++; if (qpll_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", qpll_ready); end
    checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL reset_all_ready got=%b exp=0", all_ready); end
    checks++; if (fault_count !== 16'h0000) begin errors++; $display("FAIL reset_faults got=%h exp=0000", fault_count); end
  endtask

  task automatic test_powerup();
    logic [1:0] e_pd, e_rs, e_rdy;
    qpll_lock = 2'b11;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      e_pd  = (c <= 3) ? 2'b11 : 2'b00;
      e_rs  = (c <= 6) ? 2'b11 : 2'b00;
      e_rdy = (c >= 13) ? 2'b11 : 2'b00;
      checks++; if (qpll_pd !== e_pd) begin errors++; $display("FAIL pwrup_pd cyc=%0d got=%b exp=%b", c, qpll_pd, e_pd); end
      checks++; if (qpll_reset !== e_rs) begin errors++; $display("FAIL pwrup_reset cyc=%0d got=%b exp=%b", c, qpll_reset, e_rs); end
      checks++; if (qpll_ready !== e_rdy) begin errors++; $display("FAIL pwrup_ready cyc=%0d got=%b exp=%b", c, qpll_ready, e_rdy); end
      checks++; if (all_ready !== (c >= 14)) begin errors++; $display("FAIL pwrup_all_ready cyc=%0d got=%b exp=%b", c, all_ready, (c >= 14)); end
      tick();
    end
    checks++; if (fault_count !== 16'h0000) begin errors++; $display("FAIL pwrup_faults got=%h exp=0000", fault_count); end
  endtask

  task automatic test_lock_timeout();
    logic e_rs1;
    int   e_f1;
    qpll_lock = 2'b01;
    do_reset();
    for (int c = 0; c <= 80; c++) begin
      e_rs1 = (c <= 6) || (c >= 27 && ((c - 27) % 23) < 3);
      e_f1  = (c < 27) ? 0 : ((c - 27) / 23 + 1);
      checks++; if (qpll_reset[1] !== e_rs1) begin errors++; $display("FAIL tmo_reset1 cyc=%0d got=%b exp=%b", c, qpll_reset[1], e_rs1); end
      checks++; if (fault_count[15:8] !== 8'(e_f1)) begin errors++; $display("FAIL tmo_fault1 cyc=%0d got=%0d exp=%0d", c, fault_count[15:8], e_f1); end
      checks++; if (qpll_ready[0] !== (c >= 13)) begin errors++; $display("FAIL tmo_ready0 cyc=%0d got=%b exp=%b", c, qpll_ready[0], (c >= 13)); end
      checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL tmo_all_ready cyc=%0d got=%b exp=0", c, all_ready); end
      tick();
    end
    checks++; if (fault_count[7:0] !== 8'd0) begin errors++; $display("FAIL tmo_fault0 got=%0d exp=0", fault_count[7:0]); end
  endtask

  task automatic test_lock_drop();
    qpll_lock = 2'b11;
    do_reset();
    repeat (20) tick();
    qpll_lock = 2'b10;
    for (int o = 0; o <= 14; o++) begin
      if (o == 1) qpll_lock = 2'b11;
      checks++; if (qpll_ready[0] !== (o < 3 || o >= 12)) begin errors++; $display("FAIL drop_ready0 off=%0d got=%b exp=%b", o, qpll_ready[0], (o < 3 || o >= 12)); end
      checks++; if (qpll_reset[0] !== (o >= 3 && o <= 5)) begin errors++; $display("FAIL drop_reset0 off=%0d got=%b exp=%b", o, qpll_reset[0], (o >= 3 && o <= 5)); end
      checks++; if (fault_count !== {8'd0, 8'(o >= 3)}) begin errors++; $display("FAIL drop_faults off=%0d got=%h exp=%h", o, fault_count, {8'd0, 8'(o >= 3)}); end
      checks++; if (all_ready !== (o < 4 || o >= 13)) begin errors++; $display("FAIL drop_all_ready off=%0d got=%b exp=%b", o, all_ready, (o < 4 || o >= 13)); end
      checks++; if (qpll_ready[1] !== 1'b1) begin errors++; $display("FAIL drop_ready1 off=%0d got=%b exp=1", o, qpll_ready[1]); end
      tick();
    end
  endtask

  task automatic test_settle_glitch();
    qpll_lock = 2'b11;
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      if (c == 9)  qpll_lock = 2'b10;
      if (c == 10) qpll_lock = 2'b11;
      checks++; if (qpll_ready[0] !== (c >= 21)) begin errors++; $display("FAIL settle_ready0 cyc=%0d got=%b exp=%b", c, qpll_ready[0], (c >= 21)); end
      checks++; if (qpll_reset[0] !== (c <= 6 || (c >= 12 && c <= 14))) begin errors++; $display("FAIL settle_reset0 cyc=%0d got=%b exp=%b", c, qpll_reset[0], (c <= 6 || (c >= 12 && c <= 14))); end
      checks++; if (fault_count[7:0] !== 8'(c >= 12)) begin errors++; $display("FAIL settle_fault0 cyc=%0d got=%0d exp=%0d", c, fault_count[7:0], (c >= 12)); end
      checks++; if (qpll_ready[1] !== (c >= 13)) begin errors++; $display("FAIL settle_ready1 cyc=%0d got=%b exp=%b", c, qpll_ready[1], (c >= 13)); end
      tick();
    end
  endtask

  task automatic test_refclk_lost();
    qpll_lock = 2'b11;
    do_reset();
    repeat (20) tick();
    for (int o = 0; o <= 63; o++) begin
      if (o == 0)  qpll_refclk_lost = 2'b01;
      if (o == 50) qpll_refclk_lost = 2'b00;
      checks++; if (qpll_reset[0] !== (o >= 3 && o <= 54)) begin errors++; $display("FAIL lost_reset0 off=%0d got=%b exp=%b", o, qpll_reset[0], (o >= 3 && o <= 54)); end
      checks++; if (qpll_ready[0] !== (o < 3 || o >= 61)) begin errors++; $display("FAIL lost_ready0 off=%0d got=%b exp=%b", o, qpll_ready[0], (o < 3 || o >= 61)); end
      checks++; if (fault_count !== {8'd0, 8'(o >= 3)}) begin errors++; $display("FAIL lost_faults off=%0d got=%h exp=%h", o, fault_count, {8'd0, 8'(o >= 3)}); end
      checks++; if ({qpll_ready[1], qpll_reset[1]} !== 2'b10) begin errors++; $display("FAIL lost_ch1 off=%0d got=%b%b exp=10", o, qpll_ready[1], qpll_reset[1]); end
      tick();
    end
  endtask

  task automatic test_restart_saturate();
    int drops;
    int t;
    qpll_lock = 2'b11;
    do_reset();
    repeat (20) tick();
    for (int o = 0; o <= 11; o++) begin
      if (o == 0) qpll_restart = 2'b01;
      if (o == 1) qpll_restart = 2'b00;
      checks++; if (qpll_ready[0] !== (o < 1 || o >= 10)) begin errors++; $display("FAIL rst_req_ready0 off=%0d got=%b exp=%b", o, qpll_ready[0], (o < 1 || o >= 10)); end
      checks++; if (qpll_reset[0] !== (o >= 1 && o <= 3)) begin errors++; $display("FAIL rst_req_reset0 off=%0d got=%b exp=%b", o, qpll_reset[0], (o >= 1 && o <= 3)); end
      checks++; if (fault_count !== 16'h0000) begin errors++; $display("FAIL rst_req_faults off=%0d got=%h exp=0000", o, fault_count); end
      tick();
    end
    // Ch1 loses lock from READY, then times out every 23 cycles.
    qpll_lock = 2'b01;
    drops = 0;
    for (int o = 0; o <= 3 + 23 * 300 + 12; o++) begin
      if (qpll_ready[0] !== 1'b1) drops++;
      t = -1;
      if (o == 2) t = 0;
      if (o == 3) t = 1;
      if (o == 3 + 23 * 10 - 1) t = 10;
      if (o == 3 + 23 * 10) t = 11;
      if (o == 3 + 23 * 254 - 1) t = 254;
      if (o == 3 + 23 * 254) t = 255;
      if (o == 3 + 23 * 300) t = 255;
      if (t >= 0) begin
        checks++; if (fault_count[15:8] !== 8'(t)) begin errors++; $display("FAIL sat_fault1 off=%0d got=%0d exp=%0d", o, fault_count[15:8], t); end
      end
      tick();
    end
    checks++; if (drops !== 0) begin errors++; $display("FAIL sat_ch0_drops got=%0d exp=0", drops); end
    checks++; if (fault_count[7:0] !== 8'd0) begin errors++; $display("FAIL sat_fault0 got=%0d exp=0", fault_count[7:0]); end
    // Ch1 is now in WAIT_LOCK; rst must clear everything.
    rst = 1'b1;
    tick();
    checks++; if (fault_count !== 16'h0000) begin errors++; $display("FAIL midrst_faults got=%h exp=0000", fault_count); end
    checks++; if ({qpll_pd, qpll_reset, qpll_ready} !== 6'b111100) begin errors++; $display("FAIL midrst_outs got=%b exp=111100", {qpll_pd, qpll_reset, qpll_ready}); end
    checks++; if (all_ready !== 1'b0) begin errors++; $display("FAIL midrst_all_ready got=%b exp=0", all_ready); end
    rst = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      checks++; if (qpll_pd !== ((c <= 3) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL midrst_pd cyc=%0d got=%b exp=%b", c, qpll_pd, ((c <= 3) ? 2'b11 : 2'b00)); end
      checks++; if (qpll_reset !== ((c <= 6) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL midrst_reset cyc=%0d got=%b exp=%b", c, qpll_reset, ((c <= 6) ? 2'b11 : 2'b00)); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    qpll_lock = 2'b00;
    qpll_refclk_lost = 2'b00;
    qpll_restart = 2'b00;
    test_reset();
    test_powerup();
    test_lock_timeout();
    test_lock_drop();
    test_settle_glitch();
    test_refclk_lost();
    test_restart_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
